// File: rtl/sd_block_read.sv
// -----------------------------------------------------------------------------
// sd_block_read
//
// Sequences a single 512-byte block read (CMD17) from an SD card in SPI mode,
// once card initialisation has finished. It drives a byte-level SPI exchange
// engine one byte at a time:
//   - sends the six-byte command frame;
//   - polls for the R1 response;
//   - waits for the 0xFE start token;
//   - streams the data bytes to the consumer;
//   - clocks out and discards the CRC;
//   - releases the card with chip select high for one extra byte.
// Errors such as a missing or bad R1, a missing token or a data-error token
// go through the same release path before done is signalled.
//
// Ports
//   clk         in   1   system clock, all logic on posedge
//   reset       in   1   asynchronous, active-high reset
//   req         in   1   start a read (only sampled while idle)
//   addr        in   32  block address, latched when req is accepted
//   busy        out  1   transaction in progress
//   done        out  1   one-cycle end-of-transaction pulse
//   err         out  1   transaction ended in error (valid with done, held)
//   err_code    out  3   0 ok, 1 R1 timeout, 2 R1 nonzero, 3 token timeout,
//                        4 data-error token
//   data_out    out  8   received data byte
//   data_valid  out  1   one-cycle strobe per data byte
//   data_index  out  9   index of data_out within the block
//   spi_start   out  1   one-cycle pulse: exchange spi_tx
//   spi_tx      out  8   byte to send, held until the exchange completes
//   spi_done    in   1   exchange complete, spi_rx valid this cycle
//   spi_rx      in   8   byte received by the exchange just completed
//   CS          out  1   card chip select, active low
// -----------------------------------------------------------------------------
module sd_block_read #(
    parameter int BLOCK_LEN     = 512,
    parameter int R1_TIMEOUT    = 8,
    parameter int TOKEN_TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [31:0] addr,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  err_code,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic [8:0]  data_index,
    output logic        spi_start,
    output logic [7:0]  spi_tx,
    input  logic        spi_done,
    input  logic [7:0]  spi_rx,
    output logic        CS
);

    // One shared counter serves the command byte index, both poll counters,
    // the data byte index and the CRC byte index. It is cleared on every
    // state entry, so it is sized for the largest of them.
    localparam int CNT_MAX_A = (TOKEN_TIMEOUT > BLOCK_LEN) ? TOKEN_TIMEOUT : BLOCK_LEN;
    localparam int CNT_MAX   = (CNT_MAX_A > R1_TIMEOUT) ? CNT_MAX_A : R1_TIMEOUT;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(5);
    localparam logic [CNT_W-1:0] R1_LAST    = CNT_W'(R1_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TOKEN_LAST = CNT_W'(TOKEN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(BLOCK_LEN - 1);
    localparam logic [CNT_W-1:0] CRC_LAST   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    localparam logic [7:0] CMD17_BYTE  = 8'h51;
    localparam logic [7:0] IDLE_BYTE   = 8'hFF;
    localparam logic [7:0] START_TOKEN = 8'hFE;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_R1,
        S_TOKEN,
        S_DATA,
        S_CRC,
        S_TAIL,
        S_FIN,
        S_ERR
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               in_flight_reg, in_flight_next;
    logic [31:0]        addr_reg, addr_next;
    logic               err_reg, err_next;
    logic [2:0]         err_code_reg, err_code_next;
    logic [7:0]         data_out_reg, data_out_next;
    logic               data_valid_reg, data_valid_next;
    logic [8:0]         data_index_reg, data_index_next;
    logic               spi_start_reg, spi_start_next;
    logic [7:0]         spi_tx_reg, spi_tx_next;
    logic               cs_reg, cs_next;

    logic               xchg_state;
    logic               xfer_done;
    logic [7:0]         tx_byte;

    // States that talk to the card through the exchange engine.
    assign xchg_state = (state_reg == S_CMD)   || (state_reg == S_R1)  ||
                        (state_reg == S_TOKEN) || (state_reg == S_DATA) ||
                        (state_reg == S_CRC)   || (state_reg == S_TAIL);

    // A stray spi_done with nothing outstanding (e.g. one completing after
    // a reset) is ignored.
    assign xfer_done = in_flight_reg && spi_done;

    // Byte to launch next: the command frame in CMD, 0xFF everywhere else.
    always_comb begin
        tx_byte = IDLE_BYTE;
        if (state_reg == S_CMD) begin
            case (cnt_reg[2:0])
                3'd0:    tx_byte = CMD17_BYTE;
                3'd1:    tx_byte = addr_reg[31:24];
                3'd2:    tx_byte = addr_reg[23:16];
                3'd3:    tx_byte = addr_reg[15:8];
                3'd4:    tx_byte = addr_reg[7:0];
                default: tx_byte = IDLE_BYTE;
            endcase
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        in_flight_next  = in_flight_reg;
        addr_next       = addr_reg;
        err_next        = err_reg;
        err_code_next   = err_code_reg;
        data_out_next   = data_out_reg;
        data_valid_next = 1'b0;
        data_index_next = data_index_reg;
        spi_start_next  = 1'b0;
        spi_tx_next     = spi_tx_reg;
        cs_next         = 1'b1;

        // Launch a new exchange whenever an exchanging state has nothing
        // outstanding. spi_tx is registered together with spi_start and is
        // only reloaded at the next launch, so it stays stable until done.
        if (xchg_state && !in_flight_reg) begin
            spi_start_next = 1'b1;
            spi_tx_next    = tx_byte;
            in_flight_next = 1'b1;
        end
        if (xfer_done) begin
            in_flight_next = 1'b0;
        end

        case (state_reg)
            S_IDLE: begin
                if (req) begin
                    addr_next       = addr;
                    err_next        = 1'b0;
                    err_code_next   = 3'd0;
                    data_index_next = 9'd0;
                    cnt_next        = '0;
                    state_next      = S_CMD;
                end
            end

            S_CMD: begin
                if (xfer_done) begin
                    if (cnt_reg == CMD_LAST) begin
                        cnt_next   = '0;
                        state_next = S_R1;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
            end

            S_R1: begin
                if (xfer_done) begin
                    if (spi_rx == IDLE_BYTE) begin
                        if (cnt_reg == R1_LAST) begin
                            err_next      = 1'b1;
                            err_code_next = 3'd1;
                            state_next    = S_ERR;
                        end else begin
                            cnt_next = cnt_reg + CNT_ONE;
                        end
                    end else if (spi_rx == 8'h00) begin
                        cnt_next   = '0;
                        state_next = S_TOKEN;
                    end else begin
                        err_next      = 1'b1;
                        err_code_next = 3'd2;
                        state_next    = S_ERR;
                    end
                end
            end

            S_TOKEN: begin
                if (xfer_done) begin
                    if (spi_rx == START_TOKEN) begin
                        cnt_next   = '0;
                        state_next = S_DATA;
                    end else if (spi_rx[7:4] == 4'h0) begin
                        // Data-error token: upper nibble clear.
                        err_next      = 1'b1;
                        err_code_next = 3'd4;
                        state_next    = S_ERR;
                    end else if (cnt_reg == TOKEN_LAST) begin
                        // 0xFF and any other unrecognised value count
                        // as an idle poll.
                        err_next      = 1'b1;
                        err_code_next = 3'd3;
                        state_next    = S_ERR;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
            end

            S_DATA: begin
                if (xfer_done) begin
                    data_out_next   = spi_rx;
                    data_valid_next = 1'b1;
                    data_index_next = 9'(cnt_reg);
                    if (cnt_reg == DATA_LAST) begin
                        cnt_next   = '0;
                        state_next = S_CRC;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
            end

            S_CRC: begin
                // The two CRC bytes are clocked out and dropped.
                if (xfer_done) begin
                    if (cnt_reg == CRC_LAST) begin
                        cnt_next   = '0;
                        state_next = S_TAIL;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
            end

            S_TAIL: begin
                // One 0xFF with the card deselected gives it the eight
                // clocks it needs to release the data line.
                if (xfer_done) begin
                    state_next = S_FIN;
                end
            end

            S_FIN: begin
                state_next = S_IDLE;
            end

            S_ERR: begin
                // err/err_code were loaded on entry; just head for release.
                cnt_next   = '0;
                state_next = S_TAIL;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Chip select is registered from the next state so the card pin
        // never glitches on state decoding.
        cs_next = !((state_next == S_CMD)   || (state_next == S_R1)  ||
                    (state_next == S_TOKEN) || (state_next == S_DATA) ||
                    (state_next == S_CRC));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            in_flight_reg  <= 1'b0;
            addr_reg       <= 32'd0;
            err_reg        <= 1'b0;
            err_code_reg   <= 3'd0;
            data_out_reg   <= 8'd0;
            data_valid_reg <= 1'b0;
            data_index_reg <= 9'd0;
            spi_start_reg  <= 1'b0;
            spi_tx_reg     <= IDLE_BYTE;
            cs_reg         <= 1'b1;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            in_flight_reg  <= in_flight_next;
            addr_reg       <= addr_next;
            err_reg        <= err_next;
            err_code_reg   <= err_code_next;
            data_out_reg   <= data_out_next;
            data_valid_reg <= data_valid_next;
            data_index_reg <= data_index_next;
            spi_start_reg  <= spi_start_next;
            spi_tx_reg     <= spi_tx_next;
            cs_reg         <= cs_next;
        end
    end

    // busy drops in the FIN cycle, which is also the done cycle.
    assign busy       = (state_reg != S_IDLE) && (state_reg != S_FIN);
    assign done       = (state_reg == S_FIN);
    assign err        = err_reg;
    assign err_code   = err_code_reg;
    assign data_out   = data_out_reg;
    assign data_valid = data_valid_reg;
    assign data_index = data_index_reg;
    assign spi_start  = spi_start_reg;
    assign spi_tx     = spi_tx_reg;
    assign CS         = cs_reg;

endmodule
